// File: rtl/key_expand.sv
// -----------------------------------------------------------------------------
// key_expand
//   Iterative AES-128 key schedule. A start pulse captures the 128-bit cipher
//   key. The block then presents round keys 0..NR one at a time over a
//   valid/ready handshake. Each new key is derived from the current one in a
//   single cycle, using one SubWord (four S-box lookups). Only the current
//   round key is stored.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   start      in   one-cycle request to expand cipherkey (sampled in IDLE)
//   cipherkey  in   128-bit key, byte 0 = bits [127:120]
//   ready      in   consumer accepts roundkey this cycle
//   roundkey   out  current round key, same byte order
//   round_num  out  index of the key on roundkey (0..NR)
//   valid      out  roundkey/round_num are meaningful
//   busy       out  high whenever the block is not idle
//   done       out  one-cycle pulse after key NR has been transferred
// -----------------------------------------------------------------------------
module key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] cipherkey,
    input  logic         ready,
    output logic [127:0] roundkey,
    output logic [3:0]   round_num,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // AES S-box. Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] top_bit;
        top_bit = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[top_bit -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Registers
    state_t         state_q,     state_d;
    logic [127:0]   roundkey_q,  roundkey_d;
    logic [3:0]     round_num_q, round_num_d;
    logic [7:0]     rcon_q,      rcon_d;
    logic           done_q,      done_d;

    // Next-key datapath (roundkey_q -> SubWord -> roundkey_q in one cycle)
    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    t_word;
    logic [127:0]   next_key;

    assign w0 = roundkey_q[127:96];
    assign w1 = roundkey_q[95:64];
    assign w2 = roundkey_q[63:32];
    assign w3 = roundkey_q[31:0];

    assign rot_word = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign t_word = sub_word ^ {rcon_q, 24'h000000};

    // Each new word chains off the word just produced.
    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        n0 = w0 ^ t_word;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            roundkey_q  <= '0;
            round_num_q <= '0;
            rcon_q      <= 8'h01;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            roundkey_q  <= roundkey_d;
            round_num_q <= round_num_d;
            rcon_q      <= rcon_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        roundkey_d  = roundkey_q;
        round_num_d = round_num_q;
        rcon_d      = rcon_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = EMIT;
                    roundkey_d  = cipherkey;
                    round_num_d = 4'd0;
                    rcon_d      = 8'h01;
                end
            end
            EMIT: begin
                // valid is always high in EMIT, so ready alone marks a transfer
                if (ready) begin
                    if (round_num_q == LAST_ROUND) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        roundkey_d  = next_key;
                        round_num_d = round_num_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        roundkey  = roundkey_q;
        round_num = round_num_q;
        valid     = (state_q == EMIT);
        busy      = (state_q == EMIT);
        done      = done_q;
    end

endmodule
